core_block_ctrl: RTL and testbench

CORE_BLOCK_CTRL -- requirements
Module: core_block_ctrl

---
 rtl/core_block_ctrl.sv | 150 +++++++++++++++
 tb/tb_core_block_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_block_ctrl.sv
// core_block_ctrl: launches one block of threads on a core and tracks per-thread completion.
// Latency: start at N -> thread_launch at N+1 -> RUN from N+2 -> done at N+3 at the earliest.
// Backpressure: none. start is accepted only in IDLE. DONE is terminal until reset.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start                 - one-cycle launch pulse from the block dispatcher
//   block_id              - block index, sampled with start
//   thread_count          - active threads in the block, sampled with start; clamped to THREADS_PER_BLOCK
//   thread_done           - per-thread completion, level or pulse; sampled only in RUN
//   thread_enable         - mask of active thread slots, held until reset
//   thread_launch         - one-cycle begin pulse to the enabled threads
//   block_base            - block_id*THREADS_PER_BLOCK, truncated to 8 bits
//   busy                  - high while in LAUNCH or RUN
//   done                  - block-complete level to the dispatcher
//   cycle_count           - cycles spent in LAUNCH plus RUN, saturating at 16'hFFFF
//                           (present only when CORE_BLOCK_CYCLE_COUNT_EN is defined)
//
// Build option: define CORE_BLOCK_CYCLE_COUNT_EN to add the cycle_count port and its counter.

module core_block_ctrl #(
  parameter  int THREADS_PER_BLOCK = 4,
  localparam int TCW               = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   block_id,
  input  logic [TCW-1:0]               thread_count,
  input  logic [THREADS_PER_BLOCK-1:0] thread_done,
  output logic [THREADS_PER_BLOCK-1:0] thread_enable,
  output logic                         thread_launch,
  output logic [7:0]                   block_base,
  output logic                         busy,
  output logic                         done
`ifdef CORE_BLOCK_CYCLE_COUNT_EN
  ,
  output logic [15:0]                  cycle_count
`endif
);

  localparam int LOG2T = $clog2(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                       r_state;
  logic [THREADS_PER_BLOCK-1:0] r_thread_enable;
  logic [THREADS_PER_BLOCK-1:0] r_done_mask;
  logic [7:0]                   r_block_base;
  logic                         r_thread_launch;
  logic                         r_busy;
  logic                         r_done;

  logic [TCW-1:0]               w_count_clamped;
  logic [THREADS_PER_BLOCK-1:0] w_enable_mask;
  logic [7:0]                   w_block_base;
  logic [THREADS_PER_BLOCK-1:0] w_next_mask;

  always_comb begin
    w_count_clamped = thread_count;
    if (thread_count > TCW'(THREADS_PER_BLOCK)) begin
      w_count_clamped = TCW'(THREADS_PER_BLOCK);
    end
    w_enable_mask = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      w_enable_mask[i] = (TCW'(i) < w_count_clamped);
    end
    // Multiply by a power of two is a shift; the 8-bit result truncates naturally.
    w_block_base = block_id << LOG2T;
    // Completions from slots outside the enable mask never reach the done mask.
    w_next_mask  = r_done_mask | (thread_done & r_thread_enable);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_thread_enable <= '0;
      r_done_mask     <= '0;
      r_block_base    <= '0;
      r_thread_launch <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_thread_enable <= w_enable_mask;
            r_block_base    <= w_block_base;
            r_done_mask     <= '0;
            if (w_count_clamped == '0) begin
              // Empty block: skip LAUNCH/RUN; done rises one cycle after DONE is entered.
              r_state <= ST_DONE;
            end else begin
              r_state         <= ST_LAUNCH;
              r_thread_launch <= 1'b1;
              r_busy          <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          r_thread_launch <= 1'b0;
          r_state         <= ST_RUN;
        end
        ST_RUN: begin
          r_done_mask <= w_next_mask;
          if (w_next_mask == r_thread_enable) begin
            // done is raised on the same edge so it is visible in the first DONE cycle.
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CORE_BLOCK_CYCLE_COUNT_EN
  logic [15:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_cycle_count <= '0;
    end else if (((r_state == ST_LAUNCH) || (r_state == ST_RUN)) && (r_cycle_count != 16'hFFFF)) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`endif

  assign thread_enable = r_thread_enable;
  assign thread_launch = r_thread_launch;
  assign block_base    = r_block_base;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_core_block_ctrl.sv
// tb_core_block_ctrl: directed self-checking bench for core_block_ctrl.
// Latency: n/a (inputs driven and outputs sampled 1 ns after each rising edge).
// Backpressure: n/a.

module tb_core_block_ctrl;

  localparam int T   = 4;
  localparam int TCW = $clog2(T) + 1;

  logic           clk;
  logic           reset;
  logic           start;
  logic [7:0]     block_id;
  logic [TCW-1:0] thread_count;
  logic [T-1:0]   thread_done;
  logic [T-1:0]   thread_enable;
  logic           thread_launch;
  logic [7:0]     block_base;
  logic           busy;
  logic           done;
`ifdef CORE_BLOCK_CYCLE_COUNT_EN
  logic [15:0]    cycle_count;
`endif

  int tests;
  int fails;

  core_block_ctrl #(.THREADS_PER_BLOCK(T)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .block_id      (block_id),
    .thread_count  (thread_count),
    .thread_done   (thread_done),
    .thread_enable (thread_enable),
    .thread_launch (thread_launch),
    .block_base    (block_base),
    .busy          (busy),
    .done          (done)
`ifdef CORE_BLOCK_CYCLE_COUNT_EN
    ,
    .cycle_count   (cycle_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Pulse start for one cycle; returns in the cycle after start (LAUNCH).
  task automatic do_start(input logic [7:0] id, input logic [TCW-1:0] cnt);
    start        = 1'b1;
    block_id     = id;
    thread_count = cnt;
    tick();
    start        = 1'b0;
    block_id     = 8'hEE;
    thread_count = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1; block_id = 8'h05; thread_count = 3'd4; thread_done = 4'hF;
    tick();
    tick();
    tests++; if (thread_enable !== 4'h0) begin fails++; $display("FAIL reset_enable got %h exp %h", thread_enable, 4'h0); end
    tests++; if ({thread_launch, busy, done} !== 3'b000) begin fails++; $display("FAIL reset_ctl got %b exp %b", {thread_launch, busy, done}, 3'b000); end
    tests++; if (block_base !== 8'h00) begin fails++; $display("FAIL reset_base got %h exp %h", block_base, 8'h00); end
    start = 1'b0; thread_done = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_block();
    apply_reset();
    do_start(8'd3, 3'd4);
    tests++; if (thread_launch !== 1'b1) begin fails++; $display("FAIL t1_launch got %b exp %b", thread_launch, 1'b1); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL t1_busy_launch got %b exp %b", busy, 1'b1); end
    tests++; if (block_base !== 8'd12) begin fails++; $display("FAIL t1_base got %0d exp %0d", block_base, 12); end
    tests++; if (thread_enable !== 4'b1111) begin fails++; $display("FAIL t1_enable got %b exp %b", thread_enable, 4'b1111); end
    tick();  // RUN cycle 1
    tests++; if ({thread_launch, busy, done} !== 3'b010) begin fails++; $display("FAIL t1_run1 got %b exp %b", {thread_launch, busy, done}, 3'b010); end
    tick();  // RUN cycle 2
    thread_done = 4'hF;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL t1_done_early got %b exp %b", done, 1'b0); end
    tick();
    thread_done = 4'h0;
    tests++; if ({busy, done} !== 2'b01) begin fails++; $display("FAIL t1_done got %b exp %b", {busy, done}, 2'b01); end
    tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL t1_done_hold got %b exp %b", done, 1'b1); end
    tests++; if (thread_enable !== 4'b1111) begin fails++; $display("FAIL t1_enable_hold got %b exp %b", thread_enable, 4'b1111); end
  endtask

  task automatic test_masked_done();
    apply_reset();
    thread_done = 4'b0011;  // asserted while IDLE: must not be sampled
    do_start(8'd5, 3'd2);
    tests++; if (thread_enable !== 4'b0011) begin fails++; $display("FAIL t2_enable got %b exp %b", thread_enable, 4'b0011); end
    tests++; if (block_base !== 8'd20) begin fails++; $display("FAIL t2_base got %0d exp %0d", block_base, 20); end
    thread_done = 4'b0011;  // asserted during LAUNCH: must not be sampled
    tick();  // RUN 1
    thread_done = 4'b1100;  // disabled slots
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL t2_ignored got %b exp %b", done, 1'b0); end
    thread_done = 4'b0001;
    tick();
    thread_done = 4'b0000;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL t2_first got %b exp %b", done, 1'b0); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL t2_gap got %b exp %b", done, 1'b0); end
    thread_done = 4'b0010;
    tick();
    thread_done = 4'b0000;
    tests++; if ({busy, done} !== 2'b01) begin fails++; $display("FAIL t2_second got %b exp %b", {busy, done}, 2'b01); end
  endtask

  task automatic test_zero_threads();
    apply_reset();
    do_start(8'd7, 3'd0);  // now in cycle N+1
    tests++; if ({thread_launch, busy} !== 2'b00) begin fails++; $display("FAIL t3_no_launch got %b exp %b", {thread_launch, busy}, 2'b00); end
    tick();  // cycle N+2
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL t3_done got %b exp %b", done, 1'b1); end
    tests++; if (thread_enable !== 4'b0000) begin fails++; $display("FAIL t3_enable got %b exp %b", thread_enable, 4'b0000); end
    tests++; if (block_base !== 8'd28) begin fails++; $display("FAIL t3_base got %0d exp %0d", block_base, 28); end
  endtask

  task automatic test_clamp();
    apply_reset();
    do_start(8'd65, 3'd7);  // 65*4 = 260 -> 8'd4
    tests++; if (thread_enable !== 4'b1111) begin fails++; $display("FAIL clamp_enable got %b exp %b", thread_enable, 4'b1111); end
    tests++; if (block_base !== 8'd4) begin fails++; $display("FAIL clamp_base got %0d exp %0d", block_base, 4); end
    tick();
    thread_done = 4'b0111;
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL clamp_partial got %b exp %b", done, 1'b0); end
    thread_done = 4'b1000;
    tick();
    thread_done = 4'b0000;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL clamp_done got %b exp %b", done, 1'b1); end
  endtask

  task automatic test_start_ignored();
    apply_reset();
    do_start(8'd2, 3'd3);
    tick();  // RUN 1
    start = 1'b1; block_id = 8'd9; thread_count = 3'd1;
    tick();
    start = 1'b0;
    tests++; if (block_base !== 8'd8) begin fails++; $display("FAIL t4_base got %0d exp %0d", block_base, 8); end
    tests++; if (thread_enable !== 4'b0111) begin fails++; $display("FAIL t4_enable got %b exp %b", thread_enable, 4'b0111); end
    tests++; if ({thread_launch, busy, done} !== 3'b010) begin fails++; $display("FAIL t4_state got %b exp %b", {thread_launch, busy, done}, 3'b010); end
    thread_done = 4'b0111;
    tick();
    thread_done = 4'b0000;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL t4_done got %b exp %b", done, 1'b1); end
    start = 1'b1; block_id = 8'd9; thread_count = 3'd4;
    tick();
    start = 1'b0;
    tick();
    tests++; if ({thread_launch, busy, done} !== 3'b001) begin fails++; $display("FAIL t4_done_start got %b exp %b", {thread_launch, busy, done}, 3'b001); end
    tests++; if (block_base !== 8'd8) begin fails++; $display("FAIL t4_done_base got %0d exp %0d", block_base, 8); end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    do_start(8'd4, 3'd4);
    tick();  // RUN 1
    thread_done = 4'b0011;
    tick();  // RUN 2
    thread_done = 4'b0000;
    reset = 1'b1;
    tick();
    tests++; if (thread_enable !== 4'b0000) begin fails++; $display("FAIL t5_enable got %b exp %b", thread_enable, 4'b0000); end
    tests++; if ({thread_launch, busy, done} !== 3'b000) begin fails++; $display("FAIL t5_ctl got %b exp %b", {thread_launch, busy, done}, 3'b000); end
    tests++; if (block_base !== 8'd0) begin fails++; $display("FAIL t5_base got %0d exp %0d", block_base, 0); end
    // reset held together with start: reset wins
    start = 1'b1; block_id = 8'd6; thread_count = 3'd2;
    tick();
    start = 1'b0; reset = 1'b0;
    tick();
    tests++; if ({thread_launch, busy, thread_enable} !== 6'b0) begin fails++; $display("FAIL t5_prio got %b exp %b", {thread_launch, busy, thread_enable}, 6'b0); end
    do_start(8'd1, 3'd4);
    tests++; if ({thread_launch, block_base} !== {1'b1, 8'd4}) begin fails++; $display("FAIL t5_relaunch got %h exp %h", {thread_launch, block_base}, {1'b1, 8'd4}); end
    tick();
    thread_done = 4'b1100;  // the pre-reset completions of slots 0/1 must be gone
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL t5_mask_cleared got %b exp %b", done, 1'b0); end
    thread_done = 4'b0011;
    tick();
    thread_done = 4'b0000;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL t5_done got %b exp %b", done, 1'b1); end
  endtask

`ifdef CORE_BLOCK_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    apply_reset();
    do_start(8'd0, 3'd1);
    tests++; if (cycle_count !== 16'd0) begin fails++; $display("FAIL t6_clear got %0d exp %0d", cycle_count, 0); end
    tick();  // RUN 1
    tick();
    tick();
    tick();  // RUN 4
    tick();  // RUN 5
    thread_done = 4'b0001;
    tick();
    thread_done = 4'b0000;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL t6_done got %b exp %b", done, 1'b1); end
    tests++; if (cycle_count !== 16'd6) begin fails++; $display("FAIL t6_count got %0d exp %0d", cycle_count, 6); end
    tick();
    tick();
    tests++; if (cycle_count !== 16'd6) begin fails++; $display("FAIL t6_hold got %0d exp %0d", cycle_count, 6); end
    apply_reset();
    tests++; if (cycle_count !== 16'd0) begin fails++; $display("FAIL t6_reset got %0d exp %0d", cycle_count, 0); end
    do_start(8'd0, 3'd1);
    for (int i = 0; i < 70000; i++) tick();
    tests++; if (cycle_count !== 16'hFFFF) begin fails++; $display("FAIL t6_sat got %h exp %h", cycle_count, 16'hFFFF); end
    thread_done = 4'b0001;
    tick();
    thread_done = 4'b0000;
    tick();
    tests++; if ({done, cycle_count} !== {1'b1, 16'hFFFF}) begin fails++; $display("FAIL t6_sat_done got %h exp %h", {done, cycle_count}, {1'b1, 16'hFFFF}); end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0; start = 1'b0; block_id = '0; thread_count = '0; thread_done = '0;
    test_reset();
    test_full_block();
    test_masked_done();
    test_zero_threads();
    test_clamp();
    test_start_ignored();
    test_reset_mid_run();
`ifdef CORE_BLOCK_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
